servo_pwm_bank: RTL and testbench

- Bank of NUM_SERVOS hobby-servo PWM generators.
- Consumes the packed per-servo duty bus produced by the servo mux/sequencer and drives the physical servo pins.
- Returns one end-of-period strobe per channel so the sequencer knows when a new duty has taken effect.
- Duty updates are double-buffered and take effect only at period boundaries, so there are no runt or glitched pulses.

---
 rtl/servo_pwm_bank.sv | 98 +++++++++
 tb/tb_servo_pwm_bank.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank
//   Bank of NUM_SERVOS hobby-servo PWM generators fed by the packed duty bus
//   from the servo sequencer. Each channel owns a frame counter and a shadow
//   duty register. The shadow is reloaded only while disabled or at the frame
//   wrap, so a duty change never produces a runt or glitched pulse.
//
//   Optional feature macro: SERVO_STAGGER_EN
//     When defined, channel i starts its frame offset by i*(PERIOD/NUM_SERVOS)
//     clocks from channel 0. This spreads servo inrush current over the frame.
//
// Ports
//   clk                  system clock
//   rst_n                asynchronous active-low reset
//   Enable               run PWM while high; while low, counters hold their
//                        start value and shadows track the clamped duty
//   ServoDuty            packed duties, channel i at [i*DUTY_W +: DUTY_W]
//   ServoPWM             registered PWM pins
//   ServoPeriodFinished  one-cycle strobe per channel at frame wrap; it
//                        coincides with the first cycle of the new shadow

module servo_pwm_bank #(
  parameter int unsigned NUM_SERVOS = 4,
  parameter int unsigned DUTY_W     = 21,
  parameter int unsigned PERIOD     = 2000000,
  parameter int unsigned MIN_DUTY   = 100000,
  parameter int unsigned MAX_DUTY   = 200000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         Enable,
  input  logic [NUM_SERVOS*DUTY_W-1:0] ServoDuty,
  output logic [NUM_SERVOS-1:0]        ServoPWM,
  output logic [NUM_SERVOS-1:0]        ServoPeriodFinished
);

  localparam logic [DUTY_W-1:0] LAST_CNT = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] MIN_D    = DUTY_W'(MIN_DUTY);
  localparam logic [DUTY_W-1:0] MAX_D    = DUTY_W'(MAX_DUTY);

  // Zero duty is kept as "idle"; any nonzero duty is forced into [MIN, MAX].
  function automatic logic [DUTY_W-1:0] clampDuty(input logic [DUTY_W-1:0] d);
    if (d == '0)
      return '0;
    else if (d < MIN_D)
      return MIN_D;
    else if (d > MAX_D)
      return MAX_D;
    else
      return d;
  endfunction

  for (genvar i = 0; i < NUM_SERVOS; i++) begin : gCh
`ifdef SERVO_STAGGER_EN
    localparam logic [DUTY_W-1:0] START_CNT =
      DUTY_W'((PERIOD - i * (PERIOD / NUM_SERVOS)) % PERIOD);
`else
    localparam logic [DUTY_W-1:0] START_CNT = '0;
`endif

    logic [DUTY_W-1:0] field;
    logic [DUTY_W-1:0] cntQ;
    logic [DUTY_W-1:0] shQ;
    logic              pwmQ;
    logic              finQ;

    assign field = ServoDuty[i*DUTY_W +: DUTY_W];

    // The PWM pin compares the pre-edge counter against the pre-edge shadow,
    // so the pulse covers exactly shQ cycles starting one cycle after cnt==0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cntQ <= '0;
        shQ  <= '0;
        pwmQ <= 1'b0;
        finQ <= 1'b0;
      end else if (!Enable) begin
        cntQ <= START_CNT;
        shQ  <= clampDuty(field);
        pwmQ <= 1'b0;
        finQ <= 1'b0;
      end else begin
        pwmQ <= (cntQ < shQ);
        if (cntQ == LAST_CNT) begin
          cntQ <= '0;
          shQ  <= clampDuty(field);
          finQ <= 1'b1;
        end else begin
          cntQ <= cntQ + DUTY_W'(1);
          finQ <= 1'b0;
        end
      end
    end

    assign ServoPWM[i]            = pwmQ;
    assign ServoPeriodFinished[i] = finQ;
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
module tb_servo_pwm_bank;
  localparam int N  = 4;
  localparam int W  = 21;
  localparam int P  = 100;
  localparam int MN = 5;
  localparam int MX = 20;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           Enable = 1'b0;
  logic [N*W-1:0] ServoDuty = '0;
  logic [N-1:0]   ServoPWM;
  logic [N-1:0]   ServoPeriodFinished;

  servo_pwm_bank #(
    .NUM_SERVOS(N),
    .DUTY_W    (W),
    .PERIOD    (P),
    .MIN_DUTY  (MN),
    .MAX_DUTY  (MX)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .Enable             (Enable),
    .ServoDuty          (ServoDuty),
    .ServoPWM           (ServoPWM),
    .ServoPeriodFinished(ServoPeriodFinished)
  );

  always #5 clk = ~clk;

  // Reference model: edge count since enable rose, per-channel frame phase
  // offset, and the duty latched for the frame currently being played.
  int duty[N];
  int frameDuty[N];
  int startPos[N];
  int highCnt[N];
  int firstFin[N];
  int k;
  logic [N-1:0] expPwm;
  logic [N-1:0] expFin;
  int nAssert = 0;
  int nFail = 0;

  function automatic int clampD(input int d);
    if (d == 0) return 0;
    if (d < MN) return MN;
    if (d > MX) return MX;
    return d;
  endfunction

  task automatic applyDuties();
    for (int i = 0; i < N; i++) ServoDuty[i*W +: W] = duty[i][W-1:0];
  endtask

  task automatic checkVec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    nAssert++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    nAssert++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clearStats();
    for (int i = 0; i < N; i++) begin
      highCnt[i]  = 0;
      firstFin[i] = -1;
    end
  endtask

  task automatic modelReset();
    k = 0;
    expPwm = '0;
    expFin = '0;
    for (int i = 0; i < N; i++) frameDuty[i] = 0;
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // compare on the falling edge. Inputs are only changed at falling edges.
  task automatic cycle();
    int n;
    @(posedge clk);
    if (!Enable) begin
      expPwm = '0;
      expFin = '0;
      k = 0;
      for (int i = 0; i < N; i++) frameDuty[i] = clampD(duty[i]);
    end else begin
      for (int i = 0; i < N; i++) begin
        n = (k + startPos[i]) % P;
        expPwm[i] = (n < frameDuty[i]);
        expFin[i] = (n == P - 1);
        if (n == P - 1) frameDuty[i] = clampD(duty[i]);
      end
      k++;
    end
    @(negedge clk);
    checkVec("pwm", ServoPWM, expPwm);
    checkVec("fin", ServoPeriodFinished, expFin);
    for (int i = 0; i < N; i++) begin
      if (ServoPWM[i]) highCnt[i]++;
      if (ServoPeriodFinished[i] && firstFin[i] < 0) firstFin[i] = k;
    end
  endtask

  task automatic setAll(input int d0, input int d1, input int d2, input int d3);
    duty[0] = d0; duty[1] = d1; duty[2] = d2; duty[3] = d3;
    applyDuties();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
`ifdef SERVO_STAGGER_EN
      startPos[i] = (P - i * (P / N)) % P;
`else
      startPos[i] = 0;
`endif
    end
    modelReset();
    clearStats();

    // Reset / idle
    setAll(10, 10, 10, 10);
    #12;
    checkVec("reset_pwm", ServoPWM, '0);
    checkVec("reset_fin", ServoPeriodFinished, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) cycle();

    // Basic frame plus first-strobe timing
    setAll(10, 15, 20, 5);
    cycle();
    Enable = 1'b1;
    clearStats();
    repeat (P) cycle();
    checkInt("basic_high0", highCnt[0], 10);
    checkInt("basic_high1", highCnt[1], 15);
    checkInt("basic_high2", highCnt[2], 20);
    checkInt("basic_high3", highCnt[3], 5);
    for (int i = 0; i < N; i++) checkInt("first_strobe", firstFin[i], P - startPos[i]);
    repeat (2 * P) cycle();

    // Clamp and idle channel
    Enable = 1'b0;
    setAll(0, 3, 50, 20);
    cycle();
    Enable = 1'b1;
    clearStats();
    repeat (P) cycle();
    checkInt("clamp_high0", highCnt[0], 0);
    checkInt("clamp_high1", highCnt[1], 5);
    checkInt("clamp_high2", highCnt[2], 20);
    checkInt("clamp_high3", highCnt[3], 20);

    // Mid-frame duty update on channel 0 is deferred to the next wrap
    Enable = 1'b0;
    setAll(10, 10, 10, 10);
    cycle();
    Enable = 1'b1;
    clearStats();
    repeat (40) cycle();
    duty[0] = 18;
    applyDuties();
    repeat (60) cycle();
    checkInt("midupd_old", highCnt[0], 10);
    clearStats();
    repeat (P) cycle();
    checkInt("midupd_new", highCnt[0], 18);

    // Enable drop mid-pulse
    Enable = 1'b0;
    setAll(10, 10, 10, 10);
    cycle();
    Enable = 1'b1;
    repeat (3) cycle();
    checkInt("pulse_on_ch0", int'(ServoPWM[0]), 1);
    Enable = 1'b0;
    cycle();
    checkVec("endrop_pwm", ServoPWM, '0);
    checkVec("endrop_fin", ServoPeriodFinished, '0);

    // Asynchronous reset mid-pulse
    Enable = 1'b1;
    repeat (3) cycle();
    rst_n = 1'b0;
    #1;
    checkVec("rstmid_pwm", ServoPWM, '0);
    checkVec("rstmid_fin", ServoPeriodFinished, '0);
    modelReset();
    Enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Randomized duties and enable toggling against the model
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++) duty[i] = $urandom_range(0, 60);
      applyDuties();
      Enable = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(1, 150)) cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
